// File: rtl/pc_cfr_pkg.sv
// Shared types, latency constant and fixed-point helpers for the CFR
// cancellation pulse generator.
package pc_cfr_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } cpg_state_e;

    // Edges from the sampled peak event to its first pulse sample on cp_*.
    localparam int CPG_LATENCY = 6;

    // Round half up, then drop `frac` fractional bits (arithmetic shift).
    function automatic logic signed [63:0] round_shift(input logic signed [63:0] x,
                                                       input int                 frac);
        logic signed [63:0] half;
        half = 64'sd1 <<< (frac - 1);
        return (x + half) >>> frac;
    endfunction

    // Clamp to +/-(2**(width-1)-1); the most negative code is never produced.
    function automatic logic signed [63:0] sat_sym(input logic signed [63:0] x,
                                                   input int                 width);
        logic signed [63:0] lim;
        lim = (64'sd1 <<< (width - 1)) - 64'sd1;
        if (x > lim)
            return lim;
        else if (x < -lim)
            return -lim;
        return x;
    endfunction

endpackage

// File: rtl/pc_cfr_cpg_unit.sv
// One pulse allocator: IDLE/ACTIVE state, CPW address counter, captured
// coefficient, private CPW RAM copy and pipelined complex multiply/round.
module pc_cfr_cpg_unit
    import pc_cfr_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int COEF_WIDTH     = 16,
    parameter int CPW_ADDR_WIDTH = 8,
    parameter int RND_W          = DATA_WIDTH + 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enable,
    input  logic                             start,
    input  logic signed [COEF_WIDTH-1:0]     start_coef_i,
    input  logic signed [COEF_WIDTH-1:0]     start_coef_q,
    input  logic        [CPW_ADDR_WIDTH-1:0] cpw_last,
    input  logic                             wr_en,
    input  logic        [CPW_ADDR_WIDTH-1:0] wr_addr,
    input  logic signed [DATA_WIDTH-1:0]     wr_data_i,
    input  logic signed [DATA_WIDTH-1:0]     wr_data_q,
    output logic                             busy,
    output logic signed [RND_W-1:0]          rnd_i,
    output logic signed [RND_W-1:0]          rnd_q
);

    localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;
    localparam int FULL_W = PROD_W + 1;

    cpg_state_e                      state;
    logic        [CPW_ADDR_WIDTH-1:0] addr;
    logic signed [COEF_WIDTH-1:0]     coef_i, coef_q;

    logic signed [DATA_WIDTH-1:0]     ram_i [2**CPW_ADDR_WIDTH];
    logic signed [DATA_WIDTH-1:0]     ram_q [2**CPW_ADDR_WIDTH];
    logic signed [DATA_WIDTH-1:0]     rd_i, rd_q;

    logic        [1:0]                vld_pipe;
    logic        [CPW_ADDR_WIDTH-1:0] rd_addr;
    logic signed [COEF_WIDTH-1:0]     c1_i, c1_q, c2_i, c2_q;
    logic signed [PROD_W-1:0]         pp_ii, pp_qq, pp_iq, pp_qi;
    logic signed [FULL_W-1:0]         re, im;

    assign busy = (state == ACTIVE);

    // Allocator FSM: capture on start, walk CPW addresses up to cpw_last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            addr   <= '0;
            coef_i <= '0;
            coef_q <= '0;
        end else if (!enable) begin
            state <= IDLE;
            addr  <= '0;
        end else if (start) begin
            state  <= ACTIVE;
            addr   <= '0;
            coef_i <= start_coef_i;
            coef_q <= start_coef_q;
        end else if (state == ACTIVE) begin
            if (addr == cpw_last) begin
                state <= IDLE;
                addr  <= '0;
            end else begin
                addr <= addr + 1'b1;
            end
        end
    end

    // CPW RAM copy: broadcast writes, registered read sees pre-write data.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram_i[wr_addr] <= wr_data_i;
            ram_q[wr_addr] <= wr_data_q;
        end
        rd_i <= ram_i[rd_addr];
        rd_q <= ram_q[rd_addr];
    end

    // Datapath: address reg, (RAM data), products, complex sum, round.
    // The coefficient travels with its samples so a recaptured unit never
    // rescales the tail of its previous pulse; invalid slots become zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            rd_addr  <= '0;
            c1_i     <= '0;
            c1_q     <= '0;
            c2_i     <= '0;
            c2_q     <= '0;
            pp_ii    <= '0;
            pp_qq    <= '0;
            pp_iq    <= '0;
            pp_qi    <= '0;
            re       <= '0;
            im       <= '0;
            rnd_i    <= '0;
            rnd_q    <= '0;
        end else begin
            vld_pipe <= {vld_pipe[0], busy};
            rd_addr  <= addr;
            c1_i     <= coef_i;
            c1_q     <= coef_q;
            c2_i     <= c1_i;
            c2_q     <= c1_q;
            if (vld_pipe[1]) begin
                pp_ii <= PROD_W'(rd_i) * PROD_W'(c2_i);
                pp_qq <= PROD_W'(rd_q) * PROD_W'(c2_q);
                pp_iq <= PROD_W'(rd_i) * PROD_W'(c2_q);
                pp_qi <= PROD_W'(rd_q) * PROD_W'(c2_i);
            end else begin
                pp_ii <= '0;
                pp_qq <= '0;
                pp_iq <= '0;
                pp_qi <= '0;
            end
            re    <= FULL_W'(pp_ii) - FULL_W'(pp_qq);
            im    <= FULL_W'(pp_iq) + FULL_W'(pp_qi);
            rnd_i <= RND_W'(round_shift(64'(re), COEF_WIDTH - 1));
            rnd_q <= RND_W'(round_shift(64'(im), COEF_WIDTH - 1));
        end
    end

endmodule

// File: rtl/pc_cfr_cpg_multi.sv
// Multi-allocator cancellation pulse generator: priority allocation of peak
// events to NUM_CPG pulse units, summation, symmetric saturation and drop stats.
module pc_cfr_cpg_multi
    import pc_cfr_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int COEF_WIDTH     = 16,
    parameter int CPW_ADDR_WIDTH = 8,
    parameter int NUM_CPG        = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             ctrl_enable,
    input  logic        [CPW_ADDR_WIDTH-1:0] ctrl_cpw_last,
    input  logic                             ctrl_cpw_wr_en,
    input  logic        [CPW_ADDR_WIDTH-1:0] ctrl_cpw_wr_addr,
    input  logic signed [DATA_WIDTH-1:0]     ctrl_cpw_wr_data_i,
    input  logic signed [DATA_WIDTH-1:0]     ctrl_cpw_wr_data_q,
    input  logic                             ctrl_drop_clear,
    input  logic                             peak_valid,
    input  logic signed [COEF_WIDTH-1:0]     peak_coef_i,
    input  logic signed [COEF_WIDTH-1:0]     peak_coef_q,
    output logic signed [DATA_WIDTH-1:0]     cp_i,
    output logic signed [DATA_WIDTH-1:0]     cp_q,
    output logic        [NUM_CPG-1:0]        cpg_busy,
    output logic                             peak_drop,
    output logic        [15:0]               stat_drop_count
);

    localparam int RND_W = DATA_WIDTH + 2;
    localparam int SUM_W = RND_W + $clog2(NUM_CPG);

    logic [NUM_CPG-1:0]            busy, grant, start;
    logic                          found, accept, drop;
    logic [NUM_CPG-1:0][RND_W-1:0] unit_rnd_i, unit_rnd_q;
    logic signed [SUM_W-1:0]       sum_i, sum_q;

    assign cpg_busy = busy;
    assign accept   = peak_valid & ctrl_enable;
    assign start    = accept ? grant : '0;
    assign drop     = accept & ~found;

    // Lowest-index unit that is IDLE at the start of the cycle wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_CPG; k++) begin
            if (!found && !busy[k]) begin
                grant[k] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_CPG; k++) begin : g_unit
        pc_cfr_cpg_unit #(
            .DATA_WIDTH    (DATA_WIDTH),
            .COEF_WIDTH    (COEF_WIDTH),
            .CPW_ADDR_WIDTH(CPW_ADDR_WIDTH),
            .RND_W         (RND_W)
        ) u_unit (
            .clk         (clk),
            .rst         (rst),
            .enable      (ctrl_enable),
            .start       (start[k]),
            .start_coef_i(peak_coef_i),
            .start_coef_q(peak_coef_q),
            .cpw_last    (ctrl_cpw_last),
            .wr_en       (ctrl_cpw_wr_en),
            .wr_addr     (ctrl_cpw_wr_addr),
            .wr_data_i   (ctrl_cpw_wr_data_i),
            .wr_data_q   (ctrl_cpw_wr_data_q),
            .busy        (busy[k]),
            .rnd_i       (unit_rnd_i[k]),
            .rnd_q       (unit_rnd_q[k])
        );
    end

    // Adder tree over all units; guard bits make overflow impossible here.
    always_comb begin
        sum_i = '0;
        sum_q = '0;
        for (int k = 0; k < NUM_CPG; k++) begin
            sum_i = sum_i + SUM_W'($signed(unit_rnd_i[k]));
            sum_q = sum_q + SUM_W'($signed(unit_rnd_q[k]));
        end
    end

    // Output register with symmetric saturation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cp_i <= '0;
            cp_q <= '0;
        end else begin
            cp_i <= DATA_WIDTH'(sat_sym(64'(sum_i), DATA_WIDTH));
            cp_q <= DATA_WIDTH'(sat_sym(64'(sum_q), DATA_WIDTH));
        end
    end

    // Drop pulse and saturating drop counter; clear beats increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_drop       <= 1'b0;
            stat_drop_count <= '0;
        end else begin
            peak_drop <= drop;
            if (ctrl_drop_clear)
                stat_drop_count <= '0;
            else if (drop && stat_drop_count != 16'hFFFF)
                stat_drop_count <= stat_drop_count + 16'd1;
        end
    end

endmodule
